rsa_modexp_param: RTL and testbench

RSA_MODEXP_PARAM -- requirements
Module: rsa_modexp_param

---
 rtl/rsa_modexp_param.sv | 213 +++++++++++++++++++++
 tb/tb_rsa_modexp_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_param.sv
// Modular exponentiation m^e mod n, left-to-right square-and-multiply.
// Each modular product uses an interleaved shift-add multiplier that takes
// WIDTH+1 cycles (one setup cycle plus one iteration per multiplier bit).
//
// Handshake: start is sampled only in IDLE. An accepted start captures
// message/exponent/modulus, and busy stays high until the cycle done is
// high. done is a single-cycle pulse. error is valid in that same cycle.
// result holds its value until the next accepted start reaches FINISH.
// start seen while busy (FINISH included) is dropped, not queued.
module rsa_modexp_param #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     message,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           dbg_state_o
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;

  localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_SQ     = 3'd3;
  localparam logic [2:0] S_MUL    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     r_q, r_d;        // running value of the exponentiation
  logic [WIDTH-1:0]     a_q, a_d;        // multiplicand added into the accumulator
  logic [WIDTH-1:0]     b_q, b_d;        // multiplier, shifted left each iteration
  logic [AW-1:0]        p_q, p_d;        // shift-add accumulator, always < n
  logic [CW-1:0]        cnt_q, cnt_d;    // 0 = setup, 1..WIDTH = iterations
  logic [IW-1:0]        idx_q, idx_d;    // scan pointer, then current exponent bit
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 error_q, error_d;

  logic [AW-1:0] n_ext, p_dbl, p_red1, p_sum, p_red2, p_step;
  logic [IW-1:0] idx_m1;
  logic          mul_last;

  // One shift-add step: double and reduce, then add the multiplicand and reduce.
  always_comb begin
    n_ext  = {2'b00, n_q};
    p_dbl  = p_q << 1;
    p_red1 = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
    p_sum  = p_red1 + {2'b00, a_q};
    p_red2 = (p_sum >= n_ext) ? (p_sum - n_ext) : p_sum;
    p_step = b_q[WIDTH-1] ? p_red2 : p_red1;
  end

  assign idx_m1   = idx_q - IDX_ONE;
  assign mul_last = (cnt_q == CNT_LAST);

  // Sequencer: operand check, leading-zero scan, square/multiply per bit.
  // The first set exponent bit is found by looking one bit ahead, so it
  // costs no scan cycle of its own.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = message;
          e_d     = exponent;
          n_d     = modulus;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((n_q < WIDTH'(2)) || (m_q >= n_q)) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = S_FINISH;
        end else begin
          error_d = 1'b0;
          if (e_q[IDX_TOP]) begin
            r_d     = m_q;
            idx_d   = IDX_TOP - IDX_ONE;
            cnt_d   = '0;
            state_d = S_SQ;
          end else begin
            idx_d   = IDX_TOP;
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        // bit idx_q is known to be zero; decide using the bit below it
        if (idx_q == '0) begin
          result_d = WIDTH'(1);
          r_d      = WIDTH'(1);
          state_d  = S_FINISH;
        end else if (e_q[idx_m1]) begin
          r_d = m_q;
          if (idx_m1 == '0) begin
            result_d = m_q;
            state_d  = S_FINISH;
          end else begin
            idx_d   = idx_m1 - IDX_ONE;
            cnt_d   = '0;
            state_d = S_SQ;
          end
        end else begin
          idx_d = idx_m1;
        end
      end

      S_SQ, S_MUL: begin
        if (cnt_q == '0) begin
          a_d   = r_q;
          b_d   = (state_q == S_SQ) ? r_q : m_q;
          p_d   = '0;
          cnt_d = CNT_ONE;
        end else begin
          p_d   = p_step;
          b_d   = b_q << 1;
          cnt_d = cnt_q + CNT_ONE;
          if (mul_last) begin
            cnt_d = '0;
            r_d   = p_step[WIDTH-1:0];
            if ((state_q == S_SQ) && e_q[idx_q]) begin
              state_d = S_MUL;
            end else if (idx_q == '0) begin
              result_d = p_step[WIDTH-1:0];
              state_d  = S_FINISH;
            end else begin
              idx_d   = idx_m1;
              state_d = S_SQ;
            end
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign result      = result_q;
  assign error       = error_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rsa_modexp_param.sv
// Bench for rsa_modexp_param: a 16-bit instance for directed and random
// cases and a 128-bit instance for e=65537 vectors, both checked against a
// right-to-left binary exponentiation model and the closed-form latency.
module tb_rsa_modexp_param;

  localparam int WS      = 16;
  localparam int WB      = 128;
  localparam int TIMEOUT = 6000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_s, start_b;
  logic [WS-1:0] msg_s, exp_s, mod_s, res_s;
  logic          busy_s, done_s, err_s;
  logic [2:0]    dbg_s;
  logic [WB-1:0] msg_b, exp_b, mod_b, res_b;
  logic          busy_b, done_b, err_b;
  logic [2:0]    dbg_b;

  rsa_modexp_param #(.WIDTH(WS), .EXP_WIDTH(WS)) u_small (
    .clk(clk), .reset(reset), .start(start_s),
    .message(msg_s), .exponent(exp_s), .modulus(mod_s),
    .result(res_s), .busy(busy_s), .done(done_s), .error(err_s),
    .dbg_state_o(dbg_s)
  );

  rsa_modexp_param #(.WIDTH(WB)) u_big (
    .clk(clk), .reset(reset), .start(start_b),
    .message(msg_b), .exponent(exp_b), .modulus(mod_b),
    .result(res_b), .busy(busy_b), .done(done_b), .error(err_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WB-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_lat_q[$];

  task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_err(input logic [WB-1:0] m, input logic [WB-1:0] n);
    return (n < 2) || (m >= n);
  endfunction

  function automatic logic [WB-1:0] ref_modexp(input logic [WB-1:0] m, input logic [WB-1:0] e,
                                               input logic [WB-1:0] n, input int ew);
    logic [2*WB-1:0] acc, base, nn;
    if (ref_err(m, n)) return '0;
    nn   = {{WB{1'b0}}, n};
    acc  = 1;
    base = {{WB{1'b0}}, m};
    for (int i = 0; i < ew; i++) begin
      if (e[i]) acc = (acc * base) % nn;
      base = (base * base) % nn;
    end
    return acc[WB-1:0];
  endfunction

  function automatic int ref_latency(input logic [WB-1:0] m, input logic [WB-1:0] e,
                                     input logic [WB-1:0] n, input int ew, input int w);
    int k, pop;
    if (ref_err(m, n)) return 2;
    if (e == 0) return ew + 2;
    k = 0;
    pop = 0;
    for (int i = 0; i < ew; i++) begin
      if (e[i]) begin
        k = i;
        pop++;
      end
    end
    return 2 + (ew - 1 - k) + (w + 1) * (k + pop - 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_start(input bit big, input logic [WB-1:0] m, input logic [WB-1:0] e,
                             input logic [WB-1:0] n);
    @(negedge clk);
    if (big) begin
      msg_b = m; exp_b = e; mod_b = n; start_b = 1'b1;
    end else begin
      msg_s = m[WS-1:0]; exp_s = e[WS-1:0]; mod_s = n[WS-1:0]; start_s = 1'b1;
    end
  endtask

  // lat counts rising edges from the one that samples start; -1 on timeout
  task automatic wait_done(input bit big, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        start_s = 1'b0;
        start_b = 1'b0;
      end
      if (!(big ? busy_b : busy_s)) busy_ok = 1'b0;
      if (big ? done_b : done_s) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic do_op(input bit big, input logic [WB-1:0] m, input logic [WB-1:0] e,
                       input logic [WB-1:0] n, input logic [WB-1:0] xr, input bit xe,
                       input int xl, input string tag);
    int lat;
    bit busy_ok;
    logic [WB-1:0] want_r;
    logic want_e;
    int want_l;
    exp_q.push_back(xr);
    exp_err_q.push_back(xe);
    exp_lat_q.push_back(xl);
    drive_start(big, m, e, n);
    wait_done(big, lat, busy_ok);
    want_r = exp_q.pop_front();
    want_e = exp_err_q.pop_front();
    want_l = exp_lat_q.pop_front();
    check_eq({tag, "/result"}, big ? res_b : {{(WB-WS){1'b0}}, res_s}, want_r);
    check_eq({tag, "/error"}, big ? err_b : err_s, want_e);
    check_eq({tag, "/latency"}, lat, want_l);
    check_eq({tag, "/busy"}, busy_ok, 1);
    @(posedge clk); #1;
    check_eq({tag, "/idle"}, big ? {done_b, busy_b} : {done_s, busy_s}, 0);
    check_eq({tag, "/hold"}, big ? res_b : {{(WB-WS){1'b0}}, res_s}, want_r);
  endtask

  task automatic do_rand(input bit big, input logic [WB-1:0] m, input logic [WB-1:0] e,
                         input logic [WB-1:0] n, input string tag);
    int w;
    w = big ? WB : WS;
    do_op(big, m, e, n, ref_modexp(m, e, n, w), ref_err(m, n), ref_latency(m, e, n, w, w), tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit seen_done;
    logic [WB-1:0] m, e, n;
    int r;

    reset = 1'b1;
    start_s = 1'b0; start_b = 1'b0;
    msg_s = '0; exp_s = '0; mod_s = '0;
    msg_b = '0; exp_b = '0; mod_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_small", {res_s, busy_s, done_s, err_s}, 0);
    check_eq("reset_big", {busy_b, done_b, err_b}, 0);
    check_eq("reset_big_result", res_b, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed vectors
    do_op(0, 4, 13, 497, 445, 0, 99, "basic");
    do_op(0, 65, 17, 3233, 2790, 0, 98, "rsa_enc");
    do_op(0, 2790, 2753, 3233, 65, 0, 261, "rsa_dec");
    do_op(0, 7, 0, 11, 1, 0, 18, "e_zero");
    do_op(0, 0, 5, 1, 0, 1, 2, "n_one");
    do_op(0, 11, 3, 11, 0, 1, 2, "m_eq_n");
    do_op(0, 0, 5, 13, 0, 0, 66, "m_zero");
    do_op(0, 1, 9, 13, 1, 0, 82, "m_one");
    do_op(0, 5, 1, 13, 5, 0, 17, "e_one");

    // reset wins over start in the same cycle
    @(negedge clk);
    reset = 1'b1;
    start_s = 1'b1; msg_s = 4; exp_s = 13; mod_s = 497;
    @(posedge clk); #1;
    check_eq("rst_over_start", busy_s, 0);
    reset = 1'b0;
    start_s = 1'b0;

    // load a nonzero result, then abort a run mid-way
    do_op(0, 65, 17, 3233, 2790, 0, 98, "pre_abort");
    drive_start(0, 4, 13, 497);
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start_s = 1'b0;
      if (done_s) seen_done = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_no_done", {seen_done, done_s}, 0);
    check_eq("abort_busy", busy_s, 0);
    check_eq("abort_result", res_s, 0);
    do_op(0, 4, 13, 497, 445, 0, 99, "after_abort");

    // a start pulse during a run is ignored
    drive_start(0, 4, 13, 497);
    lat = -1;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start_s = 1'b0;
      if (cyc == 10) begin
        msg_s = 65; exp_s = 17; mod_s = 3233; start_s = 1'b1;
      end
      if (cyc == 11) start_s = 1'b0;
      if (done_s) begin
        lat = cyc;
        break;
      end
    end
    check_eq("busy_start/result", res_s, 445);
    check_eq("busy_start/latency", lat, 99);

    // start during FINISH is dropped; held into IDLE it is accepted
    msg_s = 7; exp_s = 0; mod_s = 11; start_s = 1'b1;
    @(posedge clk); #1;
    check_eq("finish_start/ignored", busy_s, 0);
    check_eq("finish_start/held", res_s, 445);
    wait_done(0, lat, seen_done);
    check_eq("finish_start/result", res_s, 1);
    check_eq("finish_start/latency", lat, 18);
    @(posedge clk); #1;

    // random 16-bit vectors
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) n = $urandom_range(0, 1);
      else n = $urandom_range(2, 65535);
      if (n < 2) m = $urandom_range(0, 65535);
      else if (r == 1) m = $urandom_range(int'(n), 65535);
      else m = $urandom % n;
      if (r == 2) e = 0;
      else if (r == 3) e = 1;
      else e = $urandom_range(0, 65535);
      do_rand(0, m, e, n, $sformatf("rand16_%0d", i));
    end

    // random 128-bit vectors with e = 65537
    for (int i = 0; i < 10; i++) begin
      n = {$urandom, $urandom, $urandom, $urandom};
      if (n < 2) n = 3;
      m = {$urandom, $urandom, $urandom, $urandom};
      m = m % n;
      do_rand(1, m, 128'd65537, n, $sformatf("rand128_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
